// File: rtl/param_reservoir_if.sv
// Sample-in / activation-memory / node-out signal bundle for param_reservoir.
interface param_reservoir_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ACT_WIDTH  = 12,
  parameter int unsigned IDX_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] din;
  logic                  feedback_en;
  logic                  clear;
  logic [ADDR_WIDTH-1:0] act_addr;
  logic [ACT_WIDTH-1:0]  act_data;
  logic                  node_valid;
  logic [ACT_WIDTH-1:0]  node_dout;
  logic [IDX_WIDTH-1:0]  node_idx;
  logic                  frame_done;

  // Environment side: drives samples, control and memory read data.
  modport master (
    output in_valid, din, feedback_en, clear, act_data,
    input  in_ready, act_addr, node_valid, node_dout, node_idx, frame_done
  );

  // Reservoir side.
  modport slave (
    input  in_valid, din, feedback_en, clear, act_data,
    output in_ready, act_addr, node_valid, node_dout, node_idx, frame_done
  );
endinterface

// File: rtl/param_reservoir.sv
// Time-multiplexed delay-line reservoir: each sample plus attenuated feedback
// from the oldest node addresses an external activation memory; the returned
// activation becomes the newest virtual node.
module param_reservoir #(
  parameter int unsigned NUM_VIRTUAL_NODES = 10,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned ACT_WIDTH         = 12,
  parameter int unsigned MEM_LATENCY       = 2,
  parameter int unsigned FB_SHIFT          = 2,
  parameter int unsigned SATURATE          = 1
) (
  input logic             clk,
  input logic             rst_n,
  param_reservoir_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(NUM_VIRTUAL_NODES);
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned SUM_W    = DATA_WIDTH + 1;
  localparam int unsigned LAST_IDX = NUM_VIRTUAL_NODES - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q;
  logic                 accept_c;
  logic                 capture_c;

  logic [ACT_WIDTH-1:0] dl_q [NUM_VIRTUAL_NODES];
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     node_idx_q;
  logic [ADDR_WIDTH-1:0] act_addr_q;
  logic [ACT_WIDTH-1:0] node_dout_q;
  logic                 node_valid_q;
  logic                 frame_done_q;

  logic [DATA_WIDTH-1:0] fb_c;
  logic [SUM_W-1:0]      sum_full_c;
  logic [DATA_WIDTH-1:0] sum_c;

  // Feedback term and clamped/wrapped sum of the accepted sample.
  always_comb begin
    fb_c       = '0;
    if (bus.feedback_en) begin
      fb_c = DATA_WIDTH'(dl_q[LAST_IDX]) >> FB_SHIFT;
    end
    sum_full_c = SUM_W'(bus.din) + SUM_W'(fb_c);
    sum_c      = sum_full_c[DATA_WIDTH-1:0];
    if ((SATURATE != 0) && sum_full_c[DATA_WIDTH]) begin
      sum_c = '1;
    end
  end

  assign accept_c = in_ready_q & bus.in_valid & ~bus.clear;

  // Next-state logic: IDLE -> WAIT (MEM_LATENCY cycles) -> CAPTURE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_d   = IDLE;
        capture_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      capture_c = 1'b0;
    end
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Datapath: memory address, delay line, node index and node outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) begin
        dl_q[i] <= '0;
      end
      idx_q        <= '0;
      node_idx_q   <= '0;
      act_addr_q   <= '0;
      node_dout_q  <= '0;
      node_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) begin
        dl_q[i] <= '0;
      end
      idx_q        <= '0;
      node_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      node_valid_q <= capture_c;
      frame_done_q <= capture_c && (idx_q == IDX_W'(LAST_IDX));
      if (accept_c) begin
        act_addr_q <= sum_c[ADDR_WIDTH-1:0];
      end
      if (capture_c) begin
        for (int i = NUM_VIRTUAL_NODES - 1; i > 0; i--) begin
          dl_q[i] <= dl_q[i-1];
        end
        dl_q[0]     <= bus.act_data;
        node_dout_q <= bus.act_data;
        node_idx_q  <= idx_q;
        idx_q       <= (idx_q == IDX_W'(LAST_IDX)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.act_addr   = act_addr_q;
  assign bus.node_valid = node_valid_q;
  assign bus.node_dout  = node_dout_q;
  assign bus.node_idx   = node_idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_param_reservoir.sv
// Bench for param_reservoir: a saturating and a wrapping instance share the
// stimulus; expected node outputs are queued at accept and popped on node_valid.
module tb_param_reservoir;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic [15:0] din = '0;
  logic        fb_en = 1'b0;
  logic        clear = 1'b0;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [11:0]   n0;
    logic [11:0]   n1;
    logic [IW-1:0] idx;
    logic          fd;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] dl0 [N];
  logic [11:0] dl1 [N];
  int          midx;

  always #5 clk = ~clk;

  param_reservoir_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .ACT_WIDTH(12), .IDX_WIDTH(IW)) if0 ();
  param_reservoir_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .ACT_WIDTH(12), .IDX_WIDTH(IW)) if1 ();

  assign if0.in_valid = in_valid;
  assign if0.din = din;
  assign if0.feedback_en = fb_en;
  assign if0.clear = clear;
  assign if1.in_valid = in_valid;
  assign if1.din = din;
  assign if1.feedback_en = fb_en;
  assign if1.clear = clear;

  param_reservoir #(.NUM_VIRTUAL_NODES(N), .DATA_WIDTH(16), .ADDR_WIDTH(16), .ACT_WIDTH(12),
    .MEM_LATENCY(2), .FB_SHIFT(2), .SATURATE(1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  param_reservoir #(.NUM_VIRTUAL_NODES(N), .DATA_WIDTH(16), .ADDR_WIDTH(16), .ACT_WIDTH(12),
    .MEM_LATENCY(2), .FB_SHIFT(2), .SATURATE(0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Activation memory model: returns addr[11:0] two cycles after the address.
  logic [15:0] m0_d1, m0_d2, m1_d1, m1_d2;
  always @(posedge clk) begin
    m0_d1 <= if0.act_addr;
    m0_d2 <= m0_d1;
    m1_d1 <= if1.act_addr;
    m1_d2 <= m1_d1;
  end
  assign if0.act_data = m0_d2[11:0];
  assign if1.act_data = m1_d2[11:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_addr(input logic [15:0] d, input logic fb,
                                             input logic [11:0] tail, input bit sat);
    logic [16:0] s;
    s = {1'b0, d} + (fb ? 17'(tail >> 2) : 17'd0);
    if (sat && s[16]) return 16'hFFFF;
    return s[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      dl0[i] = '0;
      dl1[i] = '0;
    end
    midx = 0;
  endtask

  // Wait for in_ready, present one sample, check the registered address.
  task automatic send(input logic [15:0] d, input logic fb);
    int t;
    logic [15:0] a0, a1;
    t = 0;
    @(negedge clk);
    while (!if0.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    a0 = model_addr(d, fb, dl0[N-1], 1'b1);
    a1 = model_addr(d, fb, dl1[N-1], 1'b0);
    sb.push_back('{n0: a0[11:0], n1: a1[11:0], idx: IW'(midx), fd: (midx == N - 1)});
    midx = (midx + 1) % N;
    in_valid = 1'b1;
    din = d;
    fb_en = fb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fb_en = ~fb;
    din = 16'($urandom);
    check("act_addr_sat", 32'(if0.act_addr), 32'(a0));
    check("act_addr_wrap", 32'(if1.act_addr), 32'(a1));
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while (!if0.node_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check("clr_ready", 32'(if0.in_ready), 32'd1);
    check("clr_no_valid", 32'(if0.node_valid), 32'd0);
  endtask

  // Scoreboard monitor: pop expected node on every node_valid strobe.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (rst_n && if0.node_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("node_dout_sat", 32'(if0.node_dout), 32'(e.n0));
        check("node_dout_wrap", 32'(if1.node_dout), 32'(e.n1));
        check("node_idx", 32'(if0.node_idx), 32'(e.idx));
        check("frame_done", 32'(if0.frame_done), 32'(e.fd));
        check("valid_wrap", 32'(if1.node_valid), 32'd1);
        for (int i = N - 1; i > 0; i--) begin
          dl0[i] = dl0[i-1];
          dl1[i] = dl1[i-1];
        end
        dl0[0] = e.n0;
        dl1[0] = e.n1;
      end
    end
  end

  initial begin
    int vc;
    model_clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(if0.in_ready), 32'd0);
    check("rst_act_addr", 32'(if0.act_addr), 32'd0);
    check("rst_node_valid", 32'(if0.node_valid), 32'd0);
    check("rst_node_dout", 32'(if0.node_dout), 32'd0);
    check("rst_frame_done", 32'(if0.frame_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(if0.in_ready), 32'd1);

    // First sample: latency and busy window
    send(16'h0100, 1'b1);
    check("first_addr", 32'(if0.act_addr), 32'h0100);
    check("busy0", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1;
    check("busy1", 32'(if0.in_ready), 32'd0);
    check("no_valid_early", 32'(if0.node_valid), 32'd0);
    @(posedge clk); #1;
    check("busy2", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1;
    check("first_valid", 32'(if0.node_valid), 32'd1);
    check("first_dout", 32'(if0.node_dout), 32'h100);
    check("first_idx", 32'(if0.node_idx), 32'd0);
    check("ready_after_cap", 32'(if0.in_ready), 32'd1);

    // Fill frame, then feedback and wrap
    repeat (3) send(16'h0100, 1'b1);
    wait_valid();
    check("frame_idx3", 32'(if0.node_idx), 32'd3);
    check("frame_done3", 32'(if0.frame_done), 32'd1);
    send(16'h0010, 1'b1);
    check("fb_on_addr", 32'(if0.act_addr), 32'h0050);
    wait_valid();
    check("wrap_idx0", 32'(if0.node_idx), 32'd0);
    check("wrap_done0", 32'(if0.frame_done), 32'd0);

    // Feedback disabled
    do_clear();
    repeat (4) send(16'h0100, 1'b1);
    send(16'h0010, 1'b0);
    check("fb_off_addr", 32'(if0.act_addr), 32'h0010);
    wait_valid();

    // Saturate vs wrap
    do_clear();
    repeat (4) send(16'h0100, 1'b1);
    send(16'hFFF0, 1'b1);
    check("sat_addr", 32'(if0.act_addr), 32'hFFFF);
    check("wrap_addr", 32'(if1.act_addr), 32'h0030);
    wait_valid();

    // Clear during WAIT aborts the sample
    send(16'h0020, 1'b1);
    void'(sb.pop_back());
    vc = valid_cnt;
    do_clear();
    repeat (5) @(posedge clk);
    #1;
    check("clear_no_valid", 32'(valid_cnt), 32'(vc));
    send(16'h0010, 1'b1);
    check("post_clear_addr", 32'(if0.act_addr), 32'h0010);
    wait_valid();
    check("post_clear_idx", 32'(if0.node_idx), 32'd0);

    // Reset during WAIT
    send(16'h0030, 1'b1);
    void'(sb.pop_back());
    model_clear();
    vc = valid_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(if0.in_ready), 32'd0);
    check("mid_rst_addr", 32'(if0.act_addr), 32'd0);
    check("mid_rst_dout", 32'(if0.node_dout), 32'd0);
    check("mid_rst_valid", 32'(if0.node_valid), 32'd0);
    check("mid_rst_idx", 32'(if0.node_idx), 32'd0);
    check("mid_rst_frame", 32'(if0.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready_rel", 32'(if0.in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_valid", 32'(valid_cnt), 32'(vc));

    send(16'h0ABC, 1'b1);
    wait_valid();
    check("post_rst_idx", 32'(if0.node_idx), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_reservoir.md
PARAM_RESERVOIR -- requirements
Module: param_reservoir

Interface
REQ-001 SHALL have parameter NUM_VIRTUAL_NODES, default 10, delay-line length; legal range 2..1024.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, input sample and sum width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, activation-memory address width; ADDR_WIDTH <= DATA_WIDTH.
REQ-004 SHALL have parameter ACT_WIDTH, default 12, activation output and node width; ACT_WIDTH <= DATA_WIDTH.
REQ-005 SHALL have parameter MEM_LATENCY, default 2, activation-memory read latency in cycles; legal range 1..7.
REQ-006 SHALL have parameter FB_SHIFT, default 2, feedback attenuation as a right shift.
REQ-007 SHALL have parameter SATURATE, default 1; 1 = saturating sum, 0 = wrapping sum.
REQ-008 clk  input  1  single clock; all logic is on the rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  1  din carries a valid sample.
REQ-011 in_ready  output  1  block can accept a sample.
REQ-012 din  input  DATA_WIDTH  input sample, unsigned.
REQ-013 feedback_en  input  1  1 = closed-loop; 0 = feedback term forced to zero.
REQ-014 clear  input  1  synchronous flush of the delay line and node index.
REQ-015 act_addr  output  ADDR_WIDTH  registered address to the external activation memory.
REQ-016 act_data  input  ACT_WIDTH  activation memory read data, valid MEM_LATENCY cycles after act_addr changes.
REQ-017 node_valid  output  1  one-cycle strobe; node_dout and node_idx are valid.
REQ-018 node_dout  output  ACT_WIDTH  newest node value.
REQ-019 node_idx  output  clog2(NUM_VIRTUAL_NODES)  virtual-node index of node_dout.
REQ-020 frame_done  output  1  asserted with node_valid when node_idx = NUM_VIRTUAL_NODES-1.

Function
REQ-021 SHALL use the FSM states IDLE, WAIT and CAPTURE; in_ready = 1 only in IDLE.
REQ-022 Accept: in IDLE with in_valid=1 and clear=0, the block SHALL register act_addr = sum[ADDR_WIDTH-1:0] and go to WAIT.
REQ-023 sum SHALL be din + (fb >> FB_SHIFT), where fb = delay-line entry NUM_VIRTUAL_NODES-1 at the accept edge, zero-extended; fb is 0 when feedback_en=0.
REQ-024 With SATURATE=1, a sum that overflows DATA_WIDTH bits SHALL clamp to all-ones; with SATURATE=0 it SHALL wrap modulo 2^DATA_WIDTH.
REQ-025 WAIT SHALL last MEM_LATENCY cycles, counted by an internal counter, then go to CAPTURE.
REQ-026 The block SHALL capture act_data at accept edge + MEM_LATENCY + 1.
REQ-027 At that capture edge the delay line SHALL shift by one entry, entry 0 SHALL take act_data, node_dout SHALL take act_data, and the FSM SHALL return to IDLE.
REQ-028 node_valid SHALL be high for exactly the one cycle after the capture edge, with node_idx equal to the pre-increment count.
REQ-029 The node index SHALL count 0..NUM_VIRTUAL_NODES-1 and wrap to 0.
REQ-030 The next sample SHALL be accepted no earlier than the capture edge + 1 (in_ready is high in that cycle), giving a throughput of 1 sample per MEM_LATENCY+2 cycles.
REQ-031 clear=1 in any state SHALL take priority over in_valid and SHALL, at the next edge: zero the delay line, zero the node index, abort any in-flight operation with no node_valid, and enter IDLE.
REQ-032 act_addr SHALL hold its value between accepts.
REQ-033 node_dout SHALL hold its value until the next capture.
REQ-034 feedback_en SHALL be sampled only at the accept edge.

Reset
REQ-035 While rst_n=0 the block SHALL asynchronously set: state IDLE, WAIT counter 0, delay line 0, node index 0, act_addr 0, node_dout 0, node_valid 0, frame_done 0.
REQ-036 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-037 Reset asserted mid-operation SHALL discard the in-flight sample with no node_valid.

Verification (N=4, DATA_WIDTH=16, ADDR_WIDTH=16, ACT_WIDTH=12, MEM_LATENCY=2, FB_SHIFT=2; memory model returns addr[11:0] with 2-cycle latency)
REQ-038 Single sample after reset: din=0x0100 with feedback_en=1 -> act_addr=0x0100; node_valid 3 edges after accept with node_dout=0x100 and node_idx=0; in_ready low for 3 cycles.
REQ-039 Feedback: four samples of 0x0100, then din=0x0010 -> fifth act_addr=0x0050; the same stimulus with feedback_en=0 -> 0x0010.
REQ-040 Frame wrap: the fourth sample -> node_idx=3 with frame_done=1; the fifth sample -> node_idx=0 with frame_done=0.
REQ-041 Arithmetic, with delay-line entry 3 = 0x100 and din=0xFFF0: SATURATE=1 -> act_addr=0xFFFF; SATURATE=0 -> act_addr=0x0030.
REQ-042 clear asserted in WAIT -> no node_valid and in_ready=1 the next cycle; the next sample 0x0010 -> act_addr=0x0010 and node_idx=0.
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 immediately, no node_valid, in_ready=1 after release.
